path_sink: RTL

Memory-side responder for the `path` request/grant interface. It arbitrates between two `path` instances with a round-robin policy and issues one-hot grants capped at a burst length. It accepts the granted path's `valid`/`data` beats, including the one-cycle registered tail that `path` produces after a grant. Accepted beats are written sequentially into an internal log memory, which has a registered read port for downstream consumers and the testbench.

---
 rtl/path_sink.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/path_sink.sv
// Memory-side responder for two `path` requesters: round-robin burst grants,
// tail-beat drain, sequential log memory with a registered read port.
module path_sink #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = 5,
  parameter int unsigned BURST  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req1_i,
  input  logic              req2_i,
  input  logic              valid1_i,
  input  logic              valid2_i,
  input  logic [DWIDTH-1:0] data1_i,
  input  logic [DWIDTH-1:0] data2_i,
  output logic              gnt1_o,
  output logic              gnt2_o,
  input  logic              clr_i,
  input  logic              rd_en_i,
  input  logic [AWIDTH-1:0] rd_addr_i,
  output logic [DWIDTH-1:0] rd_data_o,
  output logic [AWIDTH:0]   wr_cnt_o,
  output logic              full_o,
  output logic              err_o
);

  localparam int unsigned DEPTH = 2 ** AWIDTH;
  localparam int unsigned CW    = AWIDTH + 1;
  localparam int unsigned TW    = 4;

  typedef enum logic [1:0] {IDLE, GNT1, GNT2, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        last_q, last_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d, wr_addr;
  logic [CW-1:0]     wr_cnt_q, wr_cnt_d, space;
  logic              full_q, full_d, err_q, err_d;
  logic              gnt1_q, gnt1_d, gnt2_q, gnt2_d;
  logic [DWIDTH-1:0] rd_data_q, rd_data_d, wdata;
  logic              ok1, ok2, accept, we;

  logic [DWIDTH-1:0] mem [DEPTH];

  // Beat acceptance, write pointer/count and error tracking
  always_comb begin
    ok1      = (state_q == GNT1) || (state_q == DRAIN && owner_q == 2'd1);
    ok2      = (state_q == GNT2) || (state_q == DRAIN && owner_q == 2'd2);
    accept   = (valid1_i && ok1) || (valid2_i && ok2);
    wdata    = (valid2_i && ok2) ? data2_i : data1_i;
    we       = accept && (clr_i || !full_q);
    wr_addr  = clr_i ? '0 : wr_ptr_q;
    wr_cnt_d = clr_i ? '0 : wr_cnt_q;
    err_d    = clr_i ? 1'b0 : err_q;
    wr_ptr_d = wr_addr;
    if (we) begin
      wr_ptr_d = wr_addr + AWIDTH'(1);
      wr_cnt_d = wr_cnt_d + CW'(1);
    end
    if (!clr_i && ((valid1_i && !ok1) || (valid2_i && !ok2) || (accept && full_q)))
      err_d = 1'b1;
    full_d    = (wr_cnt_d == CW'(DEPTH));
    space     = CW'(DEPTH) - wr_cnt_d;
    rd_data_d = rd_en_i ? mem[rd_addr_i] : rd_data_q;
  end

  // Arbitration and tenure control
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        if (space >= CW'(2)) begin
          if (req1_i && (!req2_i || last_q == 2'd2)) begin
            state_d = GNT1;
            owner_d = 2'd1;
            last_d  = 2'd1;
          end else if (req2_i) begin
            state_d = GNT2;
            owner_d = 2'd2;
            last_d  = 2'd2;
          end
        end
      end
      GNT1: begin
        tcnt_d = tcnt_q + TW'(1);
        if (!req1_i || tcnt_q == TW'(BURST - 1) || space <= CW'(1))
          state_d = DRAIN;
      end
      GNT2: begin
        tcnt_d = tcnt_q + TW'(1);
        if (!req2_i || tcnt_q == TW'(BURST - 1) || space <= CW'(1))
          state_d = DRAIN;
      end
      DRAIN: begin
        tcnt_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    gnt1_d = (state_d == GNT1);
    gnt2_d = (state_d == GNT2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 2'd1;
      last_q    <= 2'd2;
      tcnt_q    <= '0;
      wr_ptr_q  <= '0;
      wr_cnt_q  <= '0;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
      gnt1_q    <= 1'b0;
      gnt2_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      tcnt_q    <= tcnt_d;
      wr_ptr_q  <= wr_ptr_d;
      wr_cnt_q  <= wr_cnt_d;
      full_q    <= full_d;
      err_q     <= err_d;
      gnt1_q    <= gnt1_d;
      gnt2_q    <= gnt2_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Log storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wdata;
  end

  assign gnt1_o    = gnt1_q;
  assign gnt2_o    = gnt2_q;
  assign wr_cnt_o  = wr_cnt_q;
  assign full_o    = full_q;
  assign err_o     = err_q;
  assign rd_data_o = rd_data_q;

endmodule
